// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with req/ack memory port, skid slot and branch discard
//
// Owns the program counter, fetches instruction words over a req/ack
// handshake and registers each word with its pc+PC_STEP for decode.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   freeze         decode stall; a live output slot must hold
//   branch_taken   one-cycle redirect pulse from EX (highest priority)
//   branch_address redirect target, valid with branch_taken
//   imem_req       fetch request to instruction memory
//   imem_addr      fetch address, stable until imem_ack
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     fetched instruction word
//   pc             fetched address + PC_STEP (decode pc_in)
//   instruction    fetched word (decode instruction_in)
//   valid          pc/instruction hold a live instruction; 0 = bubble

module if_stage #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);

  logic [1:0]            state;
  logic [WORD_WIDTH-1:0] pc_reg;
  logic [WORD_WIDTH-1:0] req_addr;
  logic [WORD_WIDTH-1:0] skid_pc;
  logic [WORD_WIDTH-1:0] skid_instr;

  logic                  slot_free;
  logic [WORD_WIDTH-1:0] pc_next;

  // Decode can take a new word when the slot is empty or it is not stalling.
  assign slot_free = !valid || !freeze;
  // Wraps modulo 2^WORD_WIDTH by truncation.
  assign pc_next   = pc_reg + STEP;

  // rst gates the request so memory sees it drop as soon as reset asserts,
  // independent of the clock.
  assign imem_req  = rst && (state != HOLD);
  // In DISCARD the in-flight stale request keeps its address until acked,
  // while pc_reg already points at the redirect target.
  assign imem_addr = (state == DISCARD) ? req_addr : pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc_reg      <= RESET_PC;
      req_addr    <= '0;
      skid_pc     <= '0;
      skid_instr  <= '0;
      pc          <= '0;
      instruction <= '0;
      valid       <= 1'b0;
    end else if (branch_taken) begin
      pc_reg     <= branch_address;
      valid      <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      case (state)
        FETCH: begin
          // An ack this same cycle is simply dropped; otherwise the stale
          // request is still outstanding and must be waited out.
          if (!imem_ack) begin
            req_addr <= pc_reg;
            state    <= DISCARD;
          end
        end
        HOLD:    state <= FETCH;
        DISCARD: state <= DISCARD;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc_reg <= pc_next;
            if (slot_free) begin
              instruction <= imem_rdata;
              pc          <= pc_next;
              valid       <= 1'b1;
            end else begin
              // Decode is stalled on a live word: park the new one and stop
              // requesting until the slot drains.
              skid_instr <= imem_rdata;
              skid_pc    <= pc_next;
              state      <= HOLD;
            end
          end else if (valid && !freeze) begin
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            instruction <= skid_instr;
            pc          <= skid_pc;
            valid       <= 1'b1;
            skid_pc     <= '0;
            skid_instr  <= '0;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Registers each fetched word with its pc+4 into the IF/ID output, which decode consumes as its pc_in / instruction_in.
- Honours the hazard-unit freeze and EX-stage branch redirects, and discards stale fetches after a taken branch.

Parameters:
WORD_WIDTH, 32, width of pc, addresses and instruction words
RESET_PC, 0, fetch address after reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
freeze  input  1  hazard stall from decode; output slot must hold
branch_taken  input  1  one-cycle redirect pulse from EX
branch_address  input  WORD_WIDTH  redirect target, valid with branch_taken
imem_req  output  1  fetch request to instruction memory
imem_addr  output  WORD_WIDTH  fetch address; stable while imem_req=1 and no ack
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  WORD_WIDTH  fetched instruction word
pc  output  WORD_WIDTH  fetched address + PC_STEP, to decode pc_in
instruction  output  WORD_WIDTH  fetched word, to decode instruction_in
valid  output  1  pc/instruction hold a live instruction; 0 = bubble

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_reg=RESET_PC, state=FETCH, pc=0, instruction=0, valid=0, skid empty.
  - imem_req=0 while rst=0.
- States:
  - FETCH: request outstanding.
  - HOLD: a word is parked in the skid register and imem_req=0.
  - DISCARD: waiting out a stale request after a redirect.
- imem_req=1 in FETCH and DISCARD, 0 in HOLD.
- imem_addr:
  - FETCH: pc_reg.
  - DISCARD: the latched stale address (req_addr), so the address never changes before ack.
- Output slot "free" = (valid=0) or (freeze=0).
- FETCH with imem_ack=1, branch_taken=0:
  - Slot free: instruction<=imem_rdata, pc<=pc_reg+PC_STEP, valid<=1, pc_reg<=pc_reg+PC_STEP; stay in FETCH. The next request goes out the following cycle at the new address (back-to-back throughput of 1 per cycle when ack is immediate).
  - Slot not free: load skid with imem_rdata and pc_reg+PC_STEP, pc_reg<=pc_reg+PC_STEP, go to HOLD.
- FETCH with imem_ack=0:
  - valid=1 and freeze=0: valid<=0 (bubble).
  - freeze=1: outputs hold.
- HOLD:
  - freeze=1: everything holds.
  - freeze=0: output regs<=skid, valid<=1, skid cleared, go to FETCH.
- Latency: ack in cycle n -> valid=1 with that word in cycle n+1 when the slot is free.
- branch_taken=1 has the highest priority and overrides freeze and ack.
  - Always: pc_reg<=branch_address, valid<=0, skid cleared.
  - FETCH with ack=1 the same cycle: drop rdata, stay in FETCH; new address is issued next cycle.
  - FETCH with ack=0: req_addr<=old pc_reg, go to DISCARD.
  - HOLD: go to FETCH.
  - DISCARD: a second branch only updates pc_reg; stay in DISCARD.
- DISCARD with imem_ack=1: drop rdata, valid stays 0, go to FETCH (issues pc_reg next cycle).
- pc arithmetic is modulo 2^WORD_WIDTH; 0xFFFFFFFC + 4 wraps to 0 with no flag.
- Reset asserted mid-request: state returns to FETCH with imem_req=0 immediately; any ack arriving during reset is ignored.

Test Plan:
- Reset release, memory acks every cycle with rdata=0x1000_0000+addr -> imem_addr 0,4,8 on consecutive cycles; valid=1 from cycle after first ack; pc=4,8,12 paired with instructions 0x1000_0000, 0x1000_0004, 0x1000_0008.
- Memory acks with 2-cycle wait -> imem_addr 0 held 3 cycles; valid pulses 1 for one cycle per word with bubbles between; pc=4 then 8.
- freeze=1 for 3 cycles while valid=1 and ack arrives -> outputs unchanged, state HOLD, imem_req=0; freeze drops -> skid word appears next cycle, fetch resumes at next address.
- branch_taken with branch_address=0x200 while request to 0x10 waits 2 cycles -> valid=0 next cycle; imem_addr stays 0x10 until ack; that data is never presented; next request is 0x200, then valid with pc=0x204.
- branch_taken coincident with ack and freeze=1 -> rdata dropped, valid=0, next imem_addr=branch_address.
- pc_reg=0xFFFF_FFFC, ack -> pc output 0x0000_0000, next imem_addr 0x0000_0000; rst pulsed low mid-wait -> imem_req=0 and valid=0 asynchronously, restart at RESET_PC.
